vx_axi_write_mem_arb: RTL

//  N:1 arbiter for the AXI write path (AW/W/B), alongside the AXI read arbiter in the memory subsystem.

---
 rtl/vx_axi_write_mem_arb.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/vx_axi_write_mem_arb.sv
// N:1 AXI write-path arbiter. AW is granted round-robin into a one-entry
// output slot with the winner index inserted into AWID; W beats follow AW
// grant order through a small order FIFO; B is routed back by the ID tag.

// Per-input steering decode: W ready when this input owns the FIFO head,
// B valid when the response tag selects this input.
module vx_axi_write_mem_arb_lane #(
    parameter int IDX      = 0,
    parameter int SEL_BITS = 1
) (
    input  logic [SEL_BITS-1:0] w_head,
    input  logic                w_empty,
    input  logic                m_wready,
    input  logic [SEL_BITS-1:0] b_sel,
    input  logic                m_bvalid,
    output logic                s_wready,
    output logic                s_bvalid
);
    localparam logic [SEL_BITS-1:0] MY_SEL = SEL_BITS'(IDX);

    assign s_wready = !w_empty && (w_head == MY_SEL) && m_wready;
    assign s_bvalid = m_bvalid && (b_sel == MY_SEL);
endmodule

module vx_axi_write_mem_arb #(
    parameter int NUM_INPUTS  = 2,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 512,
    parameter int ID_WIDTH    = 8,
    parameter int TAG_SEL_IDX = 0,
    parameter int WFIFO_DEPTH = 4,
    localparam int SEL_BITS   = $clog2(NUM_INPUTS),
    localparam int OID_WIDTH  = ID_WIDTH + SEL_BITS,
    localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NUM_INPUTS-1:0]                 s_awvalid,
    output logic [NUM_INPUTS-1:0]                 s_awready,
    input  logic [NUM_INPUTS-1:0][ADDR_WIDTH-1:0] s_awaddr,
    input  logic [NUM_INPUTS-1:0][ID_WIDTH-1:0]   s_awid,
    input  logic [NUM_INPUTS-1:0][7:0]            s_awlen,
    input  logic [NUM_INPUTS-1:0][2:0]            s_awsize,
    input  logic [NUM_INPUTS-1:0][1:0]            s_awburst,
    input  logic [NUM_INPUTS-1:0]                 s_wvalid,
    input  logic [NUM_INPUTS-1:0]                 s_wlast,
    output logic [NUM_INPUTS-1:0]                 s_wready,
    input  logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] s_wdata,
    input  logic [NUM_INPUTS-1:0][STRB_WIDTH-1:0] s_wstrb,
    output logic [NUM_INPUTS-1:0]                 s_bvalid,
    input  logic [NUM_INPUTS-1:0]                 s_bready,
    output logic [NUM_INPUTS-1:0][ID_WIDTH-1:0]   s_bid,
    output logic [NUM_INPUTS-1:0][1:0]            s_bresp,
    output logic                                  m_awvalid,
    input  logic                                  m_awready,
    output logic [ADDR_WIDTH-1:0]                 m_awaddr,
    output logic [OID_WIDTH-1:0]                  m_awid,
    output logic [7:0]                            m_awlen,
    output logic [2:0]                            m_awsize,
    output logic [1:0]                            m_awburst,
    output logic                                  m_wvalid,
    input  logic                                  m_wready,
    output logic [DATA_WIDTH-1:0]                 m_wdata,
    output logic [STRB_WIDTH-1:0]                 m_wstrb,
    output logic                                  m_wlast,
    input  logic                                  m_bvalid,
    output logic                                  m_bready,
    input  logic [OID_WIDTH-1:0]                  m_bid,
    input  logic [1:0]                            m_bresp
);
    localparam int                  PTR_W    = (WFIFO_DEPTH > 1) ? $clog2(WFIFO_DEPTH) : 1;
    localparam logic [PTR_W-1:0]    PTR_LAST = PTR_W'(WFIFO_DEPTH - 1);
    localparam logic [PTR_W:0]      CNT_FULL = (PTR_W + 1)'(WFIFO_DEPTH);
    localparam logic [SEL_BITS-1:0] SEL_LAST = SEL_BITS'(NUM_INPUTS - 1);

    logic [SEL_BITS-1:0] ord_mem [WFIFO_DEPTH];
    logic [PTR_W-1:0]    rd_ptr, wr_ptr;
    logic [PTR_W:0]      ord_cnt;
    logic                ord_empty, ord_full, w_pop;
    logic [SEL_BITS-1:0] w_head;

    logic [SEL_BITS-1:0] rr_ptr, win, cand;
    logic                found, slot_free, loadable, grant;
    logic [ID_WIDTH-1:0] win_id, strip_id;
    logic [OID_WIDTH-1:0] tag_id;
    logic [SEL_BITS-1:0] b_sel;

    // W: the FIFO head owns the write data channel until its wlast passes
    assign ord_empty = (ord_cnt == '0);
    assign ord_full  = (ord_cnt == CNT_FULL);
    assign w_head    = ord_mem[rd_ptr];
    assign m_wvalid  = !ord_empty && s_wvalid[w_head];
    assign m_wdata   = s_wdata[w_head];
    assign m_wstrb   = s_wstrb[w_head];
    assign m_wlast   = s_wlast[w_head];
    assign w_pop     = m_wvalid && m_wready && m_wlast;

    // AW: a grant needs a free slot and a free FIFO entry (a same-cycle pop frees one)
    assign slot_free = !m_awvalid || m_awready;
    assign loadable  = !reset && slot_free && (!ord_full || w_pop);
    assign grant     = loadable && found;

    // Round-robin search: first valid input at or after rr_ptr, wrapping
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            cand = SEL_BITS'((int'(rr_ptr) + k) % NUM_INPUTS);
            if (!found && s_awvalid[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    // Only the winner is shown ready
    always_comb begin
        s_awready = '0;
        if (grant) s_awready[win] = 1'b1;
    end

    // Insert the winner index at TAG_SEL_IDX; upper ID bits move up by SEL_BITS
    assign win_id = s_awid[win];
    for (genvar b = 0; b < OID_WIDTH; b++) begin : g_tag
        if (b < TAG_SEL_IDX) begin : g_lo
            assign tag_id[b] = win_id[b];
        end else if (b < TAG_SEL_IDX + SEL_BITS) begin : g_sel
            assign tag_id[b] = win[b - TAG_SEL_IDX];
        end else begin : g_hi
            assign tag_id[b] = win_id[b - SEL_BITS];
        end
    end

    // B: remove the tag field to recover the source ID
    assign b_sel = m_bid[TAG_SEL_IDX +: SEL_BITS];
    for (genvar b = 0; b < ID_WIDTH; b++) begin : g_strip
        if (b < TAG_SEL_IDX) begin : g_lo
            assign strip_id[b] = m_bid[b];
        end else begin : g_hi
            assign strip_id[b] = m_bid[b + SEL_BITS];
        end
    end

    // Tags that name no input are sunk so the memory side never stalls on them
    assign m_bready = ({1'b0, b_sel} < (SEL_BITS + 1)'(NUM_INPUTS)) ? s_bready[b_sel] : 1'b1;

    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_lane
        vx_axi_write_mem_arb_lane #(
            .IDX      (i),
            .SEL_BITS (SEL_BITS)
        ) u_lane (
            .w_head   (w_head),
            .w_empty  (ord_empty),
            .m_wready (m_wready),
            .b_sel    (b_sel),
            .m_bvalid (m_bvalid),
            .s_wready (s_wready[i]),
            .s_bvalid (s_bvalid[i])
        );
        assign s_bid[i]   = strip_id;
        assign s_bresp[i] = m_bresp;
    end

    // AW slot valid: refilled by a grant, emptied when taken with no refill
    always_ff @(posedge clk or posedge reset) begin
        if (reset)          m_awvalid <= 1'b0;
        else if (slot_free) m_awvalid <= grant;
    end

    // AW slot payload: only changes on a grant, so a stalled slot stays stable
    always_ff @(posedge clk) begin
        if (grant) begin
            m_awaddr  <= s_awaddr[win];
            m_awid    <= tag_id;
            m_awlen   <= s_awlen[win];
            m_awsize  <= s_awsize[win];
            m_awburst <= s_awburst[win];
        end
    end

    // Round-robin pointer moves just past the last winner
    always_ff @(posedge clk or posedge reset) begin
        if (reset)      rr_ptr <= '0;
        else if (grant) rr_ptr <= (win == SEL_LAST) ? '0 : win + 1'b1;
    end

    // Order FIFO pointers and occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            ord_cnt <= '0;
        end else begin
            if (grant) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            if (w_pop) rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            if (grant && !w_pop)      ord_cnt <= ord_cnt + 1'b1;
            else if (!grant && w_pop) ord_cnt <= ord_cnt - 1'b1;
        end
    end

    // Order FIFO storage: winner index per grant
    always_ff @(posedge clk) begin
        if (grant) ord_mem[wr_ptr] <= win;
    end
endmodule
